// File: rtl/dac_update_scheduler_pkg.sv
// DAC instruction field definitions and scheduler types shared by the scheduler,
// the DAC serializer and any instruction decoder.
package dac_update_scheduler_pkg;

    localparam int INSTR_W     = 32;
    localparam int ADDR_FW     = 4;
    localparam int DATA_FW     = 16;

    localparam int PREFIX_LSB  = 28;
    localparam int CTRL_LSB    = 24;
    localparam int ADDR_LSB    = 20;
    localparam int DATA_LSB    = 4;
    localparam int FEATURE_LSB = 0;

    localparam logic [3:0] PREFIX        = 4'h0;
    localparam logic [3:0] CMD_WR_UPD    = 4'h3;
    localparam logic [3:0] CMD_REF_SETUP = 4'h8;
    localparam logic [3:0] REF_ON        = 4'h1;
    localparam logic [3:0] FEATURE_NONE  = 4'h0;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } sched_state_t;

    function automatic logic [INSTR_W-1:0] make_instr(
        input logic [3:0]         ctrl,
        input logic [ADDR_FW-1:0] addr,
        input logic [DATA_FW-1:0] data,
        input logic [3:0]         feature
    );
        return {PREFIX, ctrl, addr, data, feature};
    endfunction

endpackage

// File: rtl/dac_update_scheduler_if.sv
// Instruction handshake between the update scheduler and the DAC serial transmitter,
// plus the accepted-write report.
interface dac_update_scheduler_if #(
    parameter int W_ADDR = 3
);
    import dac_update_scheduler_pkg::*;

    logic [INSTR_W-1:0] tx_instr_out;
    logic               tx_valid_out;
    logic               tx_ready_in;
    logic [W_ADDR-1:0]  sent_chan_out;
    logic               sent_dv_out;

    modport master (
        output tx_instr_out,
        output tx_valid_out,
        output sent_chan_out,
        output sent_dv_out,
        input  tx_ready_in
    );

    modport slave (
        input  tx_instr_out,
        input  tx_valid_out,
        input  sent_chan_out,
        input  sent_dv_out,
        output tx_ready_in
    );
endinterface

// File: rtl/dac_update_scheduler_rr_arbiter.sv
// Round-robin picker: first requesting index at or after ptr, wrapping to index 0.
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any
);
    logic [N-1:0] mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] pick_from;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign mask[gi] = (gi >= int'(ptr));
        end
    endgenerate

    // Requests at/after the pointer take priority; otherwise wrap to the lowest request.
    assign req_hi    = req & mask;
    assign pick_from = (|req_hi) ? req_hi : req;
    assign grant     = pick_from & (~pick_from + N'(1));
    assign any       = |req;

    always_comb begin
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick_from[i]) begin
                grant_idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/dac_update_scheduler.sv
// Shares one serial DAC between N_CHAN channels: latches the newest code per channel and
// issues reference-setup first, then channel writes in round-robin order.
module dac_update_scheduler
    import dac_update_scheduler_pkg::*;
#(
    parameter int N_CHAN = 8,
    parameter int W_DATA = 16,
    parameter int W_ADDR = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [N_CHAN*W_DATA-1:0] data_in,
    input  logic [N_CHAN-1:0]        dv_in,
    input  logic [N_CHAN-1:0]        active_in,
    input  logic                     ref_set_in,
    output logic [N_CHAN-1:0]        overwrite_out,
    dac_update_scheduler_if.master   tx_if
);
    sched_state_t       state_reg, state_next;

    logic [W_DATA-1:0]  code_reg [N_CHAN];
    logic [W_DATA-1:0]  code_in  [N_CHAN];
    logic [N_CHAN-1:0]  capture;
    logic [N_CHAN-1:0]  pending_reg, pending_next;
    logic [N_CHAN-1:0]  overwrite_reg, overwrite_next;
    logic               ref_pend_reg;
    logic [W_ADDR-1:0]  rr_ptr_reg;

    logic [INSTR_W-1:0] instr_reg;
    logic               instr_is_wr_reg;
    logic [W_ADDR-1:0]  instr_chan_reg;
    logic               sent_dv_reg;
    logic [W_ADDR-1:0]  sent_chan_reg;

    logic [N_CHAN-1:0]  grant;
    logic [N_CHAN-1:0]  grant_mask;
    logic [W_ADDR-1:0]  grant_idx;
    logic               req_any;
    logic               load_ref;
    logic               load_wr;
    logic               accept;

    rr_arbiter #(
        .N (N_CHAN),
        .W (W_ADDR)
    ) u_rr_arbiter (
        .req       (pending_reg),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (req_any)
    );

    assign grant_mask = load_wr ? grant : '0;

    // A dv landing on the channel being granted simply re-arms it; it is not an overwrite.
    genvar gi;
    generate
        for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
            assign code_in[gi]        = data_in[gi*W_DATA +: W_DATA];
            assign capture[gi]        = dv_in[gi] & active_in[gi];
            assign overwrite_next[gi] = capture[gi] & pending_reg[gi] & ~grant_mask[gi];
            assign pending_next[gi]   = !active_in[gi] ? 1'b0 :
                                        dv_in[gi]      ? 1'b1 :
                                        grant_mask[gi] ? 1'b0 : pending_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        load_ref   = 1'b0;
        load_wr    = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ref_pend_reg) begin
                    load_ref   = 1'b1;
                    state_next = ST_SEND;
                end else if (req_any) begin
                    load_wr    = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_if.tx_ready_in) begin
                    accept     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < N_CHAN; i++) begin
            if (capture[i]) begin
                code_reg[i] <= code_in[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pending_reg   <= '0;
            overwrite_reg <= '0;
        end else begin
            pending_reg   <= pending_next;
            overwrite_reg <= overwrite_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            instr_reg       <= '0;
            instr_is_wr_reg <= 1'b0;
            instr_chan_reg  <= '0;
            sent_dv_reg     <= 1'b0;
            sent_chan_reg   <= '0;
            ref_pend_reg    <= 1'b0;
            rr_ptr_reg      <= '0;
        end else begin
            sent_dv_reg <= accept & instr_is_wr_reg;
            if (accept && instr_is_wr_reg) begin
                sent_chan_reg <= instr_chan_reg;
            end
            if (load_ref) begin
                instr_reg       <= make_instr(CMD_REF_SETUP, '0, '0, REF_ON);
                instr_is_wr_reg <= 1'b0;
            end
            if (load_wr) begin
                instr_reg       <= make_instr(CMD_WR_UPD, ADDR_FW'(grant_idx),
                                              DATA_FW'(code_reg[grant_idx]), FEATURE_NONE);
                instr_is_wr_reg <= 1'b1;
                instr_chan_reg  <= grant_idx;
                rr_ptr_reg      <= (grant_idx == W_ADDR'(N_CHAN - 1)) ? '0
                                                                      : grant_idx + W_ADDR'(1);
            end
            // A new request arriving while the previous one is being loaded is kept.
            if (ref_set_in) begin
                ref_pend_reg <= 1'b1;
            end else if (load_ref) begin
                ref_pend_reg <= 1'b0;
            end
        end
    end

    assign tx_if.tx_instr_out  = instr_reg;
    assign tx_if.tx_valid_out  = (state_reg == ST_SEND);
    assign tx_if.sent_dv_out   = sent_dv_reg;
    assign tx_if.sent_chan_out = sent_chan_reg;
    assign overwrite_out       = overwrite_reg;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Self-checking bench for dac_update_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_dac_update_scheduler;
    import dac_update_scheduler_pkg::*;

    localparam int N  = 8;
    localparam int WD = 16;
    localparam int WA = 3;

    logic            clk_in = 1'b0;
    logic            rst_n_in = 1'b0;
    logic [N*WD-1:0] data_in = '0;
    logic [N-1:0]    dv_in = '0;
    logic [N-1:0]    active_in = '0;
    logic            ref_set_in = 1'b0;
    logic [N-1:0]    overwrite_out;

    dac_update_scheduler_if #(.W_ADDR(WA)) tx_if ();

    dac_update_scheduler #(
        .N_CHAN (N),
        .W_DATA (WD),
        .W_ADDR (WA)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .data_in       (data_in),
        .dv_in         (dv_in),
        .active_in     (active_in),
        .ref_set_in    (ref_set_in),
        .overwrite_out (overwrite_out),
        .tx_if         (tx_if)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sdv_cnt  = 0;
    int ovw_cnt  = 0;
    int valid_cnt = 0;
    logic [31:0] acc_q [$];

    // Model state: what the scheduler must hold, tracked per channel with plain ints.
    bit          m_pend [N];
    int          m_code [N];
    bit          m_refp;
    int          m_ptr;
    bit          m_busy;
    logic [31:0] m_instr;
    bit          m_is_wr;
    int          m_ch;
    bit          m_sent_dv;
    int          m_sent_ch;
    logic [N-1:0] m_ovw;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%08h required=%08h", nm, cyc, act, exp);
        end
    endfunction

    function automatic int chan_of(logic [31:0] instr);
        return int'((instr >> ADDR_LSB) & 32'h7);
    endfunction

    function automatic void model_step();
        int g;
        bit old_pend [N];
        if (!rst_n_in) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_refp = 0; m_ptr = 0; m_busy = 0; m_instr = '0; m_is_wr = 0;
            m_ch = 0; m_sent_dv = 0; m_sent_ch = 0; m_ovw = '0;
            return;
        end
        g = -1;
        old_pend = m_pend;
        m_sent_dv = 0;
        if (!m_busy) begin
            if (m_refp) begin
                m_instr = 32'h08000001;
                m_is_wr = 0;
                m_refp  = 0;
                m_busy  = 1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (g < 0 && m_pend[c]) g = c;
                end
                if (g >= 0) begin
                    m_instr   = 32'h03000000 | (32'(g) << 20) | (32'(m_code[g]) << 4);
                    m_is_wr   = 1;
                    m_ch      = g;
                    m_pend[g] = 0;
                    m_ptr     = (g + 1) % N;
                    m_busy    = 1;
                end
            end
        end else if (tx_if.tx_ready_in) begin
            m_busy = 0;
            if (m_is_wr) begin
                m_sent_dv = 1;
                m_sent_ch = m_ch;
            end
        end
        m_ovw = '0;
        for (int i = 0; i < N; i++) begin
            if (!active_in[i]) begin
                m_pend[i] = 0;
            end else if (dv_in[i]) begin
                if (old_pend[i] && i != g) m_ovw[i] = 1'b1;
                m_code[i] = int'(data_in[i*WD +: WD]);
                m_pend[i] = 1;
            end
        end
        if (ref_set_in) m_refp = 1;
    endfunction

    function automatic void compare();
        chk("valid", 32'(tx_if.tx_valid_out), 32'(m_busy));
        if (m_busy) chk("instr", tx_if.tx_instr_out, m_instr);
        chk("sent_dv", 32'(tx_if.sent_dv_out), 32'(m_sent_dv));
        chk("sent_chan", 32'(tx_if.sent_chan_out), 32'(m_sent_ch));
        chk("overwrite", 32'(overwrite_out), 32'(m_ovw));
    endfunction

    task automatic tick();
        bit          acc;
        bit          rst_ok;
        logic [31:0] ai;
        acc    = tx_if.tx_valid_out && tx_if.tx_ready_in;
        ai     = tx_if.tx_instr_out;
        rst_ok = rst_n_in;
        @(posedge clk_in);
        model_step();
        #1;
        compare();
        if (acc && rst_ok) begin
            acc_q.push_back(ai);
            $display("xfer cyc=%0d instr=%08h", cyc, ai);
        end
        if (tx_if.sent_dv_out) sdv_cnt++;
        if (tx_if.tx_valid_out) valid_cnt++;
        ovw_cnt += $countones(overwrite_out);
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_in();
        dv_in = '0;
        ref_set_in = 1'b0;
    endtask

    task automatic set_dv(input int ch, input int val);
        dv_in[ch] = 1'b1;
        data_in[ch*WD +: WD] = WD'(val);
    endtask

    task automatic do_reset();
        clear_in();
        rst_n_in = 1'b0;
        ticks(2);
        rst_n_in = 1'b1;
        active_in = '1;
        tx_if.tx_ready_in = 1'b1;
        acc_q.delete();
        sdv_cnt = 0;
        ovw_cnt = 0;
        valid_cnt = 0;
    endtask

    initial begin
        tx_if.tx_ready_in = 1'b0;

        // Reset state
        rst_n_in = 1'b0;
        ticks(2);
        chk("rst_valid", 32'(tx_if.tx_valid_out), 32'd0);
        chk("rst_instr", tx_if.tx_instr_out, 32'd0);
        chk("rst_sent_dv", 32'(tx_if.sent_dv_out), 32'd0);
        chk("rst_ovw", 32'(overwrite_out), 32'd0);
        do_reset();

        // 1: single write, latency and encoding
        set_dv(0, 500);
        tick();
        clear_in();
        chk("t1_valid_t1", 32'(tx_if.tx_valid_out), 32'd0);
        tick();
        chk("t1_valid_t2", 32'(tx_if.tx_valid_out), 32'd1);
        chk("t1_instr", tx_if.tx_instr_out, 32'h03001F40);
        tick();
        chk("t1_sent_dv", 32'(tx_if.sent_dv_out), 32'd1);
        chk("t1_sent_chan", 32'(tx_if.sent_chan_out), 32'd0);
        ticks(3);

        // 2: round-robin order
        do_reset();
        set_dv(0, 11); set_dv(2, 22); set_dv(5, 55);
        tick();
        clear_in();
        ticks(8);
        set_dv(0, 33); set_dv(7, 77);
        tick();
        clear_in();
        ticks(6);
        chk("t2_count", 32'(acc_q.size()), 32'd5);
        if (acc_q.size() == 5) begin
            chk("t2_ord0", 32'(chan_of(acc_q[0])), 32'd0);
            chk("t2_ord1", 32'(chan_of(acc_q[1])), 32'd2);
            chk("t2_ord2", 32'(chan_of(acc_q[2])), 32'd5);
            chk("t2_ord3", 32'(chan_of(acc_q[3])), 32'd7);
            chk("t2_ord4", 32'(chan_of(acc_q[4])), 32'd0);
        end

        // 3: reference command ahead of a write
        do_reset();
        ref_set_in = 1'b1;
        set_dv(4, 16'h1234);
        tick();
        clear_in();
        ticks(6);
        chk("t3_count", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2) begin
            chk("t3_ref", acc_q[0], 32'h08000001);
            chk("t3_wr", acc_q[1], 32'h03412340);
        end
        chk("t3_sdv_cnt", 32'(sdv_cnt), 32'd1);

        // 4: overwrite while the transmitter is stalled
        do_reset();
        tx_if.tx_ready_in = 1'b0;
        set_dv(1, 7);
        tick();
        clear_in();
        tick();
        set_dv(3, 100);
        tick();
        set_dv(3, 200);
        tick();
        clear_in();
        chk("t4_ovw_pulse", 32'(overwrite_out), 32'h08);
        ticks(2);
        tx_if.tx_ready_in = 1'b1;
        ticks(6);
        chk("t4_ovw_cnt", 32'(ovw_cnt), 32'd1);
        chk("t4_count", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2) chk("t4_wr", acc_q[1], 32'h03300C80);

        // 5: inactive channels
        do_reset();
        active_in[1] = 1'b0;
        set_dv(1, 9);
        tick();
        clear_in();
        ticks(3);
        chk("t5_no_valid", 32'(valid_cnt), 32'd0);
        active_in = '1;
        tx_if.tx_ready_in = 1'b0;
        set_dv(0, 1);
        tick();
        clear_in();
        tick();
        set_dv(6, 66);
        tick();
        clear_in();
        active_in[6] = 1'b0;
        tick();
        active_in[6] = 1'b1;
        tx_if.tx_ready_in = 1'b1;
        ticks(6);
        chk("t5_count", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() == 1) chk("t5_chan", 32'(chan_of(acc_q[0])), 32'd0);

        // 6: reset during SEND abandons everything
        do_reset();
        tx_if.tx_ready_in = 1'b0;
        set_dv(0, 1);
        tick();
        clear_in();
        tick();
        set_dv(2, 2); set_dv(3, 3);
        tick();
        clear_in();
        tick();
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
        chk("t6_valid", 32'(tx_if.tx_valid_out), 32'd0);
        acc_q.delete();
        tx_if.tx_ready_in = 1'b1;
        ticks(6);
        chk("t6_count", 32'(acc_q.size()), 32'd0);

        // Randomized traffic, checked every cycle against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                dv_in[i] = ($urandom_range(0, 3) == 0);
                data_in[i*WD +: WD] = WD'($urandom);
                active_in[i] = ($urandom_range(0, 15) != 0);
            end
            ref_set_in = ($urandom_range(0, 19) == 0);
            tx_if.tx_ready_in = ($urandom_range(0, 2) != 0);
            rst_n_in = ($urandom_range(0, 199) != 0);
            tick();
        end
        clear_in();
        rst_n_in = 1'b1;
        ticks(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
